// File: rtl/alu_share_ctrl_if.sv
// Requester / shared-ALU / response bundle for alu_share_ctrl.
// The slave modport is the controller side; master is the side that issues
// requests, provides the combinational ALU result and accepts responses.
interface alu_share_ctrl_if #(
    parameter int N       = 8,
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [3*NUM_REQ-1:0] req_op;
    logic [N*NUM_REQ-1:0] req_a;
    logic [N*NUM_REQ-1:0] req_b;
    logic [2:0]           alu_op;
    logic [N-1:0]         alu_a;
    logic [N-1:0]         alu_b;
    logic [N-1:0]         alu_result;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [N-1:0]         resp_data;
    logic [IDW-1:0]       resp_id;
    logic                 busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_result, resp_ready,
        output req_ready, alu_op, alu_a, alu_b, resp_valid, resp_data, resp_id, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_result, resp_ready,
        input  req_ready, alu_op, alu_a, alu_b, resp_valid, resp_data, resp_id, busy
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational ALU among NUM_REQ requesters.
// IDLE picks a winner, EXEC drives the ALU and captures its result, RESP holds
// the tagged result until accepted.
// Optional macro ALU_SHARE_CTRL_PERF_EN adds op_count / stall_count outputs.
module alu_share_ctrl #(
    parameter int N       = 8,
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic clk,
    input  logic rst_n,
    alu_share_ctrl_if.slave bus
`ifdef ALU_SHARE_CTRL_PERF_EN
    ,
    output logic [15:0] op_count,
    output logic [15:0] stall_count
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state;
    logic [IDW-1:0]     rr;
    logic [IDW-1:0]     w_r;
    logic [IDW-1:0]     win;
    logic               found;
    logic [IDW:0]       idx;
    logic [NUM_REQ-1:0] ready;
    logic               accept;
    logic               resp_hs;

    // Winner search: walk offsets high to low so the smallest offset from rr wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NUM_REQ))
                idx = idx - (IDW+1)'(NUM_REQ);
            if (bus.req_valid[idx[IDW-1:0]]) begin
                win   = idx[IDW-1:0];
                found = 1'b1;
            end
        end
    end

    // Grant only the winner, and only while idle.
    always_comb begin
        ready = '0;
        if (state == IDLE && found)
            ready[win] = 1'b1;
    end

    assign bus.req_ready = ready;
    assign accept        = (state == IDLE) && found;
    assign resp_hs       = (state == RESP) && bus.resp_ready;

    // Sequencer: ALU operand registers double as the alu_* outputs, so they
    // only change on a grant and hold their last values while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr             <= '0;
            w_r            <= '0;
            bus.alu_op     <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_id    <= '0;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    bus.alu_op <= bus.req_op[int'(win)*3 +: 3];
                    bus.alu_a  <= bus.req_a[int'(win)*N +: N];
                    bus.alu_b  <= bus.req_b[int'(win)*N +: N];
                    w_r        <= win;
                    bus.busy   <= 1'b1;
                    state      <= EXEC;
                end
                EXEC: begin
                    bus.resp_data  <= bus.alu_result;
                    bus.resp_id    <= w_r;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: if (bus.resp_ready) begin
                    bus.resp_valid <= 1'b0;
                    bus.busy       <= 1'b0;
                    rr             <= (w_r == IDW'(NUM_REQ - 1)) ? '0 : w_r + 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SHARE_CTRL_PERF_EN
    // Saturating counters for completed responses and back-pressured cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count    <= '0;
            stall_count <= '0;
        end else begin
            if (resp_hs && op_count != 16'hFFFF)
                op_count <= op_count + 16'd1;
            if (state == RESP && !bus.resp_ready && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed + randomized bench for alu_share_ctrl; the bench also acts as the
// shared combinational ALU.
module tb_alu_share_ctrl;
    localparam int N   = 8;
    localparam int NR  = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_share_ctrl_if #(.N(N), .NUM_REQ(NR), .IDW(IDW)) bus ();

`ifdef ALU_SHARE_CTRL_PERF_EN
    logic [15:0] op_count, stall_count;
    alu_share_ctrl #(.N(N), .NUM_REQ(NR), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .op_count(op_count), .stall_count(stall_count));
`else
    alu_share_ctrl #(.N(N), .NUM_REQ(NR), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            3'd6: return (a < b) ? 8'd1 : 8'd0;
            default: return a;
        endcase
    endfunction

    always_comb bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model state
    bit         pend [NR];
    logic [2:0] m_op [NR];
    logic [7:0] m_a  [NR];
    logic [7:0] m_b  [NR];
    int         rr_m;
    int         m_ops;
    int         m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]         = pend[i];
            bus.req_op[3*i +: 3]     = m_op[i];
            bus.req_a[N*i +: N]      = m_a[i];
            bus.req_b[N*i +: N]      = m_b[i];
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        pend[i] = 1'b1;
        m_op[i] = op;
        m_a[i]  = a;
        m_b[i]  = b;
    endtask

    // First pending requester at or after rr_m, wrapping.
    function automatic int pick();
        for (int k = 0; k < NR; k++)
            if (pend[(rr_m + k) % NR]) return (rr_m + k) % NR;
        return -1;
    endfunction

    // Called at a negedge in IDLE with requests driven. Walks one full
    // transaction: grant, EXEC, RESP (with 'stall' back-pressured cycles).
    task automatic serve(input int id, input int stall, input bit keep);
        logic [7:0] exp_d;
        exp_d = alu_fn(m_op[id], m_a[id], m_b[id]);
        #1 check("grant", 32'(bus.req_ready), 32'(1 << id));
        bus.resp_ready = (stall == 0);
        @(negedge clk);
        if (!keep) begin
            pend[id] = 1'b0;
            drive_reqs();
        end
        check("exec_busy", 32'(bus.busy), 1);
        check("exec_rvalid", 32'(bus.resp_valid), 0);
        check("exec_op", 32'(bus.alu_op), 32'(m_op[id]));
        check("exec_a", 32'(bus.alu_a), 32'(m_a[id]));
        check("exec_b", 32'(bus.alu_b), 32'(m_b[id]));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.resp_valid), 1);
            check("stall_data", 32'(bus.resp_data), 32'(exp_d));
            check("stall_id", 32'(bus.resp_id), id);
            check("stall_ready", 32'(bus.req_ready), 0);
        end
        if (stall != 0) begin
            @(negedge clk);
            bus.resp_ready = 1'b1;
        end else begin
            @(negedge clk);
        end
        check("resp_valid", 32'(bus.resp_valid), 1);
        check("resp_data", 32'(bus.resp_data), 32'(exp_d));
        check("resp_id", 32'(bus.resp_id), id);
        check("resp_req_ready", 32'(bus.req_ready), 0);
        @(negedge clk);
        check("idle_valid", 32'(bus.resp_valid), 0);
        check("idle_busy", 32'(bus.busy), 0);
        rr_m = (id + 1) % NR;
        m_ops++;
        m_stall += stall;
`ifdef ALU_SHARE_CTRL_PERF_EN
        check("op_count", 32'(op_count), m_ops);
        check("stall_count", 32'(stall_count), m_stall);
`endif
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        bus.resp_ready = 1'b1;
        bus.req_valid = '0;
        bus.req_op = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        for (int i = 0; i < NR; i++) begin
            pend[i] = 0; m_op[i] = 0; m_a[i] = 0; m_b[i] = 0;
        end
        rr_m = 0; m_ops = 0; m_stall = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_resp_valid", 32'(bus.resp_valid), 0);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_resp_data", 32'(bus.resp_data), 0);
        check("rst_resp_id", 32'(bus.resp_id), 0);
        check("rst_alu_op", 32'(bus.alu_op), 0);
        check("rst_alu_a", 32'(bus.alu_a), 0);
        check("rst_alu_b", 32'(bus.alu_b), 0);
        check("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request: sltu 03 < F0 from requester 1
        set_req(1, 3'd6, 8'h03, 8'hF0);
        drive_reqs();
        serve(1, 0, 0);

        // Wrap arithmetic and signed compare boundary
        set_req(2, 3'd0, 8'hFF, 8'h01); drive_reqs(); serve(pick(), 0, 0);
        set_req(3, 3'd1, 8'h00, 8'h01); drive_reqs(); serve(pick(), 0, 0);
        set_req(0, 3'd5, 8'h80, 8'h01); drive_reqs(); serve(pick(), 0, 0);

        // alu_* hold last values while idle
        repeat (2) @(negedge clk);
        check("idle_hold_op", 32'(bus.alu_op), 5);
        check("idle_hold_a", 32'(bus.alu_a), 32'h80);

        // Back-pressure for 5 cycles
        set_req(1, 3'd4, 8'h5A, 8'h0F); drive_reqs(); serve(pick(), 5, 0);

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            if (pick() < 0) begin
                w = int'($urandom_range(0, NR - 1));
                set_req(w, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            end
            drive_reqs();
            serve(pick(), int'($urandom_range(0, 2)), 0);
        end

        // Reset mid-operation: in-flight op from requester 2 is dropped
        for (int i = 0; i < NR; i++) pend[i] = 0;
        set_req(2, 3'd3, 8'h11, 8'h22);
        drive_reqs();
        @(negedge clk);             // now in EXEC
        rst_n = 1'b0;
        pend[2] = 0;
        drive_reqs();
        #1;
        check("mid_rst_valid", 32'(bus.resp_valid), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_alu_op", 32'(bus.alu_op), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rr_m = 0; m_ops = 0; m_stall = 0;
        repeat (2) @(negedge clk);
        check("post_rst_valid", 32'(bus.resp_valid), 0);
        // rr back at 0: with 1 and 3 pending, 1 must win
        set_req(1, 3'd2, 8'hF0, 8'h3C);
        set_req(3, 3'd7, 8'hA5, 8'h00);
        drive_reqs();
        serve(pick(), 0, 0);
        serve(pick(), 0, 0);

        // All requesters continuously valid: order 0,1,2,3,0,1
        for (int i = 0; i < NR; i++)
            set_req(i, 3'(i), 8'(8'h10 + i), 8'(8'h03 * (i + 1)));
        drive_reqs();
        for (int k = 0; k < 6; k++)
            serve(k % NR, 0, 1);
        for (int i = 0; i < NR; i++) pend[i] = 0;
        drive_reqs();
        #1 check("final_ready", 32'(bus.req_ready), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
